la_capture_buf: RTL and testbench

LA_CAPTURE_BUF -- requirements
Module: la_capture_buf

---
 rtl/la_capture_buf.sv | 168 ++++++++++++++++
 tb/tb_la_capture_buf.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_buf.sv
// la_capture_buf
// ---------------------------------------------------------------------------
// Logic-analyser capture buffer: a 64 x 8 circular sample memory with
// pre-trigger / post-trigger windowing. After an arm pulse the buffer first
// collects pre_depth samples, then keeps writing and wrapping until a trigger
// lands on a sample strobe. It then fills the rest of the 64-entry buffer and
// freezes. The display side reads the frozen buffer in chronological order:
// rd_addr = 0 is the oldest stored sample.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sample_en  sample strobe (one sample per high cycle)
//   din[7:0]   probe channels
//   arm        single-cycle start/restart pulse (has priority over trig)
//   trig       qualified trigger
//   pre_depth  pre-trigger sample count, latched at arm
//   rd_addr    display read index (0 = oldest)
//   rd_data    registered read data (1-cycle latency)
//   busy       capture in progress
//   triggered  trigger accepted in the current capture
//   done       buffer frozen and valid for display
//   trig_pos   physical address of the trigger sample
// ---------------------------------------------------------------------------
module la_capture_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [7:0] din,
    input  logic       arm,
    input  logic       trig,
    input  logic [5:0] pre_depth,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       triggered,
    output logic       done,
    output logic [5:0] trig_pos
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_FILL,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [5:0] wr_ptr_reg, wr_ptr_next;
    logic [5:0] fill_cnt_reg, fill_cnt_next;
    logic [5:0] post_cnt_reg, post_cnt_next;
    logic [5:0] pre_lat_reg, pre_lat_next;
    logic [5:0] trig_pos_reg, trig_pos_next;
    logic       triggered_reg, triggered_next;
    logic       wr_en;

    logic [7:0] mem [0:63];
    logic [7:0] rd_data_reg;
    logic [5:0] start_addr;
    logic [5:0] rd_idx;

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        fill_cnt_next  = fill_cnt_reg;
        post_cnt_next  = post_cnt_reg;
        pre_lat_next   = pre_lat_reg;
        trig_pos_next  = trig_pos_reg;
        triggered_next = triggered_reg;
        wr_en          = 1'b0;

        if (arm) begin
            // Restart from any state; the arm cycle itself stores nothing.
            pre_lat_next   = pre_depth;
            wr_ptr_next    = 6'd0;
            fill_cnt_next  = 6'd0;
            triggered_next = 1'b0;
            state_next     = (pre_depth == 6'd0) ? S_WAIT_TRIG : S_PRE_FILL;
        end else begin
            case (state_reg)
                S_PRE_FILL: begin
                    if (sample_en) begin
                        wr_en         = 1'b1;
                        wr_ptr_next   = wr_ptr_reg + 6'd1;
                        fill_cnt_next = fill_cnt_reg + 6'd1;
                        // Leave as the pre_lat-th sample is being written.
                        if (fill_cnt_reg + 6'd1 == pre_lat_reg)
                            state_next = S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    if (sample_en) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 6'd1;
                        if (trig) begin
                            trig_pos_next  = wr_ptr_reg;
                            triggered_next = 1'b1;
                            post_cnt_next  = 6'd63 - pre_lat_reg;
                            // A full pre-trigger window leaves no room after.
                            state_next = (pre_lat_reg == 6'd63) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (sample_en) begin
                        wr_en         = 1'b1;
                        wr_ptr_next   = wr_ptr_reg + 6'd1;
                        post_cnt_next = post_cnt_reg - 6'd1;
                        if (post_cnt_reg == 6'd1)
                            state_next = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= 6'd0;
            fill_cnt_reg  <= 6'd0;
            post_cnt_reg  <= 6'd0;
            pre_lat_reg   <= 6'd0;
            trig_pos_reg  <= 6'd0;
            triggered_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            fill_cnt_reg  <= fill_cnt_next;
            post_cnt_reg  <= post_cnt_next;
            pre_lat_reg   <= pre_lat_next;
            trig_pos_reg  <= trig_pos_next;
            triggered_reg <= triggered_next;
        end
    end

    // ------------------------------------------------------------------
    // Sample memory: contents are never reset; writes are blocked during rst.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_ptr_reg] <= din;
    end

    // Oldest stored sample sits pre_lat entries before the trigger sample.
    assign start_addr = trig_pos_reg - pre_lat_reg;
    assign rd_idx     = start_addr + rd_addr;

    always_ff @(posedge clk) begin
        if (rst)
            rd_data_reg <= 8'd0;
        else
            rd_data_reg <= mem[rd_idx];
    end

    assign rd_data   = rd_data_reg;
    assign busy      = (state_reg == S_PRE_FILL) || (state_reg == S_WAIT_TRIG) ||
                       (state_reg == S_POST);
    assign done      = (state_reg == S_DONE);
    assign triggered = triggered_reg;
    assign trig_pos  = trig_pos_reg;

endmodule

// File: tb/tb_la_capture_buf.sv
// tb_la_capture_buf
// Directed bench for la_capture_buf. Inputs change just after a falling edge
// and outputs are sampled on the next falling edge, i.e. half a cycle after
// the rising edge that consumed the inputs.
module tb_la_capture_buf;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic [7:0] din;
    logic       arm;
    logic       trig;
    logic [5:0] pre_depth;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       triggered;
    logic       done;
    logic [5:0] trig_pos;

    int n_vec = 0;
    int n_err = 0;

    la_capture_buf dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .din       (din),
        .arm       (arm),
        .trig      (trig),
        .pre_depth (pre_depth),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .triggered (triggered),
        .done      (done),
        .trig_pos  (trig_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One arm pulse with no sample strobe in the same cycle.
    task automatic do_arm(input logic [5:0] depth);
        arm       = 1'b1;
        pre_depth = depth;
        sample_en = 1'b0;
        trig      = 1'b0;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || trig_pos !== 6'd0 || rd_data !== 8'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b trig=%b done=%b pos=%h rd=%h, want 0 0 0 00 00",
                     busy, triggered, done, trig_pos, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: checked idle outputs");
    endtask

    task automatic test_no_pretrig;
        do_arm(6'd0);
        for (int k = 0; k <= 8'h4F; k++) begin
            sample_en = 1'b1;
            din       = 8'(k);
            trig      = (k == 16);
            @(negedge clk);
            if (k == 16) begin
                n_vec++;
                if (triggered !== 1'b1 || trig_pos !== 6'h10 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL d0_trig: trig=%b pos=%h busy=%b, want 1 10 1", triggered, trig_pos, busy);
                end
            end
            if (k == 8'h4E) begin
                n_vec++;
                if (done !== 1'b0) begin
                    n_err++;
                    $display("FAIL d0_early_done: done=%b, want 0", done);
                end
            end
        end
        sample_en = 1'b0;
        trig      = 1'b0;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL d0_done: done=%b busy=%b, want 1 0", done, busy);
        end
        rd_addr = 6'd0;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h10) begin
            n_err++;
            $display("FAIL d0_rd0: got %h, want 10", rd_data);
        end
        rd_addr = 6'd63;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h4F) begin
            n_err++;
            $display("FAIL d0_rd63: got %h, want 4f", rd_data);
        end
        $display("no_pretrig: trig_pos=%h", trig_pos);
    endtask

    task automatic test_prefill_wrap;
        do_arm(6'd8);
        for (int k = 0; k <= 8'h87; k++) begin
            if (k == 0) pre_depth = 6'd5;  // must not affect this capture
            sample_en = 1'b1;
            din       = 8'(k);
            trig      = (k == 3) || (k == 8'h50);
            @(negedge clk);
            if (k == 3) begin
                n_vec++;
                if (triggered !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL d8_prefill_trig: trig=%b busy=%b, want 0 1", triggered, busy);
                end
            end
            if (k == 8'h50) begin
                n_vec++;
                if (triggered !== 1'b1 || trig_pos !== 6'h10) begin
                    n_err++;
                    $display("FAIL d8_trig: trig=%b pos=%h, want 1 10", triggered, trig_pos);
                end
            end
            if (k == 8'h86) begin
                n_vec++;
                if (done !== 1'b0) begin
                    n_err++;
                    $display("FAIL d8_early_done: done=%b, want 0", done);
                end
            end
        end
        sample_en = 1'b0;
        trig      = 1'b0;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL d8_done: done=%b, want 1", done);
        end
        rd_addr = 6'd0;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h48) begin
            n_err++;
            $display("FAIL d8_rd0: got %h, want 48", rd_data);
        end
        rd_addr = 6'd8;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h50) begin
            n_err++;
            $display("FAIL d8_rd8: got %h, want 50", rd_data);
        end
        rd_addr = 6'd63;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h87) begin
            n_err++;
            $display("FAIL d8_rd63: got %h, want 87", rd_data);
        end
        $display("prefill_wrap: trig_pos=%h", trig_pos);
    endtask

    task automatic test_full_pre;
        do_arm(6'd63);
        for (int k = 0; k <= 8'h50; k++) begin
            sample_en = 1'b1;
            din       = 8'(k);
            trig      = (k == 8'h50);
            @(negedge clk);
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || trig_pos !== 6'h10) begin
            n_err++;
            $display("FAIL d63_done: done=%b busy=%b pos=%h, want 1 0 10", done, busy, trig_pos);
        end
        // Strobes while frozen must not write.
        for (int k = 0; k < 4; k++) begin
            sample_en = 1'b1;
            din       = 8'hAA;
            trig      = 1'b1;
            @(negedge clk);
        end
        sample_en = 1'b0;
        trig      = 1'b0;
        rd_addr = 6'd0;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h11) begin
            n_err++;
            $display("FAIL d63_rd0: got %h, want 11", rd_data);
        end
        rd_addr = 6'd62;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h4F) begin
            n_err++;
            $display("FAIL d63_rd62: got %h, want 4f", rd_data);
        end
        rd_addr = 6'd63;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h50) begin
            n_err++;
            $display("FAIL d63_rd63: got %h, want 50", rd_data);
        end
        $display("full_pre: done=%b", done);
    endtask

    task automatic test_sparse;
        int s;
        s = 0;
        do_arm(6'd4);
        // Ten strobes; trig only ever high on non-strobe cycles.
        for (int c = 0; c < 40; c++) begin
            sample_en = (c % 4 == 0);
            trig      = (c % 4 == 2);
            din       = 8'(8'h20 + s);
            if (c % 4 == 0) s++;
            @(negedge clk);
        end
        n_vec++;
        if (triggered !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL sparse_offstrobe: trig=%b busy=%b, want 0 1", triggered, busy);
        end
        sample_en = 1'b1;
        trig      = 1'b1;
        din       = 8'h2A;
        @(negedge clk);
        n_vec++;
        if (triggered !== 1'b1 || trig_pos !== 6'd10) begin
            n_err++;
            $display("FAIL sparse_trig: trig=%b pos=%h, want 1 0a", triggered, trig_pos);
        end
        trig = 1'b0;
        for (int j = 1; j <= 59; j++) begin
            sample_en = 1'b0;
            repeat (3) @(negedge clk);
            sample_en = 1'b1;
            din       = 8'(8'h2A + j);
            @(negedge clk);
            if (j == 58) begin
                n_vec++;
                if (done !== 1'b0) begin
                    n_err++;
                    $display("FAIL sparse_early_done: done=%b, want 0", done);
                end
            end
        end
        sample_en = 1'b0;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL sparse_done: done=%b, want 1", done);
        end
        rd_addr = 6'd0;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h26) begin
            n_err++;
            $display("FAIL sparse_rd0: got %h, want 26", rd_data);
        end
        rd_addr = 6'd4;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h2A) begin
            n_err++;
            $display("FAIL sparse_rd4: got %h, want 2a", rd_data);
        end
        rd_addr = 6'd63;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h65) begin
            n_err++;
            $display("FAIL sparse_rd63: got %h, want 65", rd_data);
        end
        $display("sparse: trig_pos=%h", trig_pos);
    endtask

    task automatic test_abort_rearm;
        do_arm(6'd2);
        for (int k = 0; k < 6; k++) begin
            sample_en = 1'b1;
            din       = 8'(k);
            trig      = (k == 3);
            @(negedge clk);
        end
        trig = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || trig_pos !== 6'd0) begin
            n_err++;
            $display("FAIL abort_rst: busy=%b trig=%b done=%b pos=%h, want 0 0 0 00",
                     busy, triggered, done, trig_pos);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b, want 0", busy);
        end
        do_arm(6'd3);
        for (int k = 0; k < 4; k++) begin
            sample_en = 1'b1;
            din       = 8'(8'h60 + k);
            @(negedge clk);
        end
        do_arm(6'd1);
        n_vec++;
        if (busy !== 1'b1 || triggered !== 1'b0) begin
            n_err++;
            $display("FAIL rearm_state: busy=%b trig=%b, want 1 0", busy, triggered);
        end
        sample_en = 1'b1;
        din       = 8'h77;
        trig      = 1'b1;  // still in PRE_FILL: ignored
        @(negedge clk);
        din = 8'h78;
        @(negedge clk);
        sample_en = 1'b0;
        trig      = 1'b0;
        n_vec++;
        if (triggered !== 1'b1 || trig_pos !== 6'd1) begin
            n_err++;
            $display("FAIL rearm_trig: trig=%b pos=%h, want 1 01", triggered, trig_pos);
        end
        $display("abort_rearm: trig_pos=%h", trig_pos);
    endtask

    task automatic test_arm_trig;
        arm       = 1'b1;
        pre_depth = 6'd0;
        trig      = 1'b1;
        sample_en = 1'b1;
        din       = 8'hEE;
        @(negedge clk);
        arm = 1'b0;
        n_vec++;
        if (triggered !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL armtrig_same: trig=%b busy=%b, want 0 1", triggered, busy);
        end
        din = 8'h33;
        @(negedge clk);
        trig = 1'b0;
        n_vec++;
        if (triggered !== 1'b1 || trig_pos !== 6'd0) begin
            n_err++;
            $display("FAIL armtrig_next: trig=%b pos=%h, want 1 00", triggered, trig_pos);
        end
        for (int j = 0; j < 63; j++) begin
            din = 8'(8'h34 + j);
            @(negedge clk);
        end
        sample_en = 1'b0;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL armtrig_done: done=%b, want 1", done);
        end
        rd_addr = 6'd0;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h33) begin
            n_err++;
            $display("FAIL armtrig_rd0: got %h, want 33", rd_data);
        end
        rd_addr = 6'd63;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 8'h72) begin
            n_err++;
            $display("FAIL armtrig_rd63: got %h, want 72", rd_data);
        end
        $display("arm_trig: trig_pos=%h", trig_pos);
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        din       = 8'd0;
        arm       = 1'b0;
        trig      = 1'b0;
        pre_depth = 6'd0;
        rd_addr   = 6'd0;
        test_reset;
        test_no_pretrig;
        test_prefill_wrap;
        test_full_pre;
        test_sparse;
        test_abort_rearm;
        test_arm_trig;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
